// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
// Shared definitions for the counter run controller: default sizing and the
// legacy-compatible state encoding that is also exported on o_state.
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    // Default counter width, matching the 10-bit LED counter on the board.
    localparam int CNT_W_DEF = 10;

    // Default prescale: one count tick per second from the 50 MHz clock.
    localparam int PRESC_DEF = 50_000_000;

    // State encodings. They are visible on o_state, so the values are fixed.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

endpackage : counter_ctrl_pkg

// File: rtl/counter_ctrl_if.sv
// -----------------------------------------------------------------------------
// counter_ctrl_if
// Control bus between the run controller and the up/down counter datapath.
// The controller (master) issues enable/load strobes and the direction; the
// counter (slave) feeds its current value back for the terminal compare.
// -----------------------------------------------------------------------------
interface counter_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             cnt_en;    // one-cycle count-enable tick
    logic             cnt_up;    // count direction, 1 = up
    logic             cnt_load;  // one-cycle load strobe
    logic [CNT_W-1:0] load_val;  // value to load, valid with cnt_load
    logic [CNT_W-1:0] cnt_dat;   // current counter value

    modport master (
        output cnt_en,
        output cnt_up,
        output cnt_load,
        output load_val,
        input  cnt_dat
    );

    modport slave (
        input  cnt_en,
        input  cnt_up,
        input  cnt_load,
        input  load_val,
        output cnt_dat
    );

endinterface : counter_ctrl_if

// File: rtl/key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
// Turns an asynchronous active-low push-button level into a single-cycle
// press pulse: two-flop synchronizer, a previous-value register, and a
// falling-edge detect. Everything rests at "released" (1) out of reset, so a
// key held down through reset release is seen as exactly one fresh press.
// -----------------------------------------------------------------------------
module key_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronize the key and keep its previous synchronized value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each flop take the value its
            // predecessor held before this edge, which is what forms the chain.
            sync1_q <= i_key_n;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Press = key was released last cycle and is pressed now.
    assign o_press = prev_q & ~sync2_q;

endmodule : key_edge

// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl
// Run controller for the lab up/down counter. Start and pause keys become
// single-cycle commands; a prescaler derives the count tick; at each tick the
// fed-back counter value is compared with the terminal value to decide between
// counting, reloading (wrap) and stopping (one-shot). All outputs registered.
//
// Command latency: a key first sampled low at edge k takes effect at edge k+2.
// The prescaler advances on every edge where the registered state is RUN, so
// the RUN cycles between two ticks always add up to PRESC, however long the
// controller sits in PAUSE in between.
// -----------------------------------------------------------------------------
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PRESC = PRESC_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_n,
    input  logic             i_pause_n,
    input  logic             i_up,
    input  logic             i_wrap,
    input  logic [CNT_W-1:0] i_limit,
    counter_ctrl_if.master   cnt_bus,
    output logic [1:0]       o_state,
    output logic             o_done
);

    // Prescaler sizing; PRESC >= 2 keeps this at least one bit wide and gives
    // the counter a full cycle to settle after each strobe before the compare.
    localparam int             PW         = $clog2(PRESC);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESC - 1);

    // Key commands.
    logic start_cmd;
    logic pause_cmd;

    // Controller state and mode latched at start.
    logic [1:0]       state_q;
    logic [PW-1:0]    presc_q;
    logic             up_q;
    logic             wrap_q;
    logic [CNT_W-1:0] limit_q;

    // Registered outputs.
    logic             en_q;
    logic             load_q;
    logic [CNT_W-1:0] load_val_q;
    logic             done_q;

    // Tick decode and terminal compare.
    logic             tick;
    logic [CNT_W-1:0] term_val;
    logic [CNT_W-1:0] start_val;
    logic             at_terminal;
    logic             one_shot_end;

    key_edge u_start_key (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key_n (i_start_n),
        .o_press (start_cmd)
    );

    key_edge u_pause_key (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key_n (i_pause_n),
        .o_press (pause_cmd)
    );

    // Up mode counts 0 -> limit; down mode counts limit -> 0.
    assign term_val     = up_q ? limit_q : '0;
    assign start_val    = up_q ? '0 : limit_q;
    assign tick         = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign at_terminal  = (cnt_bus.cnt_dat == term_val);
    assign one_shot_end = tick && at_terminal && !wrap_q;

    // Command handling, prescaler and terminal-count sequencing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            up_q       <= 1'b0;
            wrap_q     <= 1'b0;
            limit_q    <= '0;
            en_q       <= 1'b0;
            load_q     <= 1'b0;
            load_val_q <= '0;
            done_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            en_q   <= 1'b0;
            load_q <= 1'b0;

            if (start_cmd) begin
                // Start (or restart) from any state; it outranks pause and any
                // tick due this cycle, so enable and load never coincide.
                up_q       <= i_up;
                wrap_q     <= i_wrap;
                limit_q    <= i_limit;
                load_val_q <= i_up ? '0 : i_limit;
                load_q     <= 1'b1;
                presc_q    <= '0;
                state_q    <= ST_RUN;
                done_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (tick) begin
                            presc_q <= '0;
                            if (!at_terminal) begin
                                en_q <= 1'b1;
                            end else if (wrap_q) begin
                                load_q     <= 1'b1;
                                load_val_q <= start_val;
                            end
                        end else begin
                            presc_q <= presc_q + 1'b1;
                        end

                        // Reaching the end of a one-shot run takes precedence
                        // over a pause landing on the same edge.
                        if (one_shot_end) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (pause_cmd) begin
                            state_q <= ST_PAUSE;
                        end
                    end

                    ST_PAUSE: begin
                        // Prescaler holds; resume carries on from that value.
                        if (pause_cmd) begin
                            state_q <= ST_RUN;
                        end
                    end

                    // IDLE and DONE wait for a start; pause is ignored here.
                    default: ;
                endcase
            end
        end
    end

    assign cnt_bus.cnt_en   = en_q;
    assign cnt_bus.cnt_up   = up_q;
    assign cnt_bus.cnt_load = load_q;
    assign cnt_bus.load_val = load_val_q;
    assign o_state          = state_q;
    assign o_done           = done_q;

endmodule : counter_ctrl

// File: tb/tb_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_ctrl
// Directed bench for counter_ctrl with PRESC=4, CNT_W=10 and a behavioural
// counter that applies load/enable on the cycle after each strobe.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_ctrl;

    localparam int CNT_W = 10;
    localparam int PRESC = 4;

    logic             clk = 1'b0;
    logic             i_rst;
    logic             i_start_n;
    logic             i_pause_n;
    logic             i_up;
    logic             i_wrap;
    logic [CNT_W-1:0] i_limit;
    logic [1:0]       o_state;
    logic             o_done;

    int tests_run    = 0;
    int tests_failed = 0;
    int both_cnt     = 0;

    counter_ctrl_if #(.CNT_W(CNT_W)) bus ();

    counter_ctrl #(.CNT_W(CNT_W), .PRESC(PRESC)) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_start_n (i_start_n),
        .i_pause_n (i_pause_n),
        .i_up      (i_up),
        .i_wrap    (i_wrap),
        .i_limit   (i_limit),
        .cnt_bus   (bus),
        .o_state   (o_state),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    // Behavioural counter: loads or steps on the edge after the strobe.
    logic [CNT_W-1:0] cnt = '0;
    assign bus.cnt_dat = cnt;
    always @(posedge clk) begin
        if (bus.cnt_load === 1'b1)
            cnt <= bus.load_val;
        else if (bus.cnt_en === 1'b1)
            cnt <= (bus.cnt_up === 1'b1) ? cnt + 10'd1 : cnt - 10'd1;
    end

    // Enable and load must never be high together.
    always @(negedge clk) begin
        if (bus.cnt_en === 1'b1 && bus.cnt_load === 1'b1) both_cnt++;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press start; on return the load strobe should be visible (edge k+2).
    task automatic press_start();
        i_start_n = 1'b0;
        repeat (3) step();
        i_start_n = 1'b1;
    endtask

    task automatic test_reset();
        int strobes = 0;
        int bad_st  = 0;
        i_rst = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        tests_run++; if (bus.cnt_en !== 1'b0) begin tests_failed++; $display("FAIL reset_en: got %b want 0", bus.cnt_en); end
        tests_run++; if (bus.cnt_up !== 1'b0) begin tests_failed++; $display("FAIL reset_up: got %b want 0", bus.cnt_up); end
        tests_run++; if (bus.cnt_load !== 1'b0) begin tests_failed++; $display("FAIL reset_load: got %b want 0", bus.cnt_load); end
        tests_run++; if (bus.load_val !== 10'd0) begin tests_failed++; $display("FAIL reset_load_val: got %0d want 0", bus.load_val); end
        tests_run++; if (o_state !== 2'b00) begin tests_failed++; $display("FAIL reset_state: got %b want 00", o_state); end
        tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", o_done); end
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.cnt_en !== 1'b0 || bus.cnt_load !== 1'b0) strobes++;
            if (o_state !== 2'b00) bad_st++;
        end
        tests_run++; if (strobes !== 0) begin tests_failed++; $display("FAIL reset_quiet: got %0d strobe cycles want 0", strobes); end
        tests_run++; if (bad_st !== 0) begin tests_failed++; $display("FAIL reset_idle: got %0d non-IDLE cycles want 0", bad_st); end
    endtask

    task automatic test_up_oneshot();
        int en_at[8];
        int n_en    = 0;
        int done_at = -1;
        foreach (en_at[i]) en_at[i] = -1;
        i_up = 1'b1; i_wrap = 1'b0; i_limit = 10'd5;
        press_start();
        tests_run++; if (bus.cnt_load !== 1'b1) begin tests_failed++; $display("FAIL up1_load: got %b want 1", bus.cnt_load); end
        tests_run++; if (bus.load_val !== 10'd0) begin tests_failed++; $display("FAIL up1_load_val: got %0d want 0", bus.load_val); end
        tests_run++; if (o_state !== 2'b01) begin tests_failed++; $display("FAIL up1_state_run: got %b want 01", o_state); end
        tests_run++; if (bus.cnt_up !== 1'b1) begin tests_failed++; $display("FAIL up1_dir: got %b want 1", bus.cnt_up); end
        for (int c = 1; c <= 30; c++) begin
            step();
            if (bus.cnt_en === 1'b1) begin
                if (n_en < 8) en_at[n_en] = c;
                n_en++;
            end
            if (o_done === 1'b1 && done_at < 0) done_at = c;
        end
        tests_run++; if (n_en !== 5) begin tests_failed++; $display("FAIL up1_en_count: got %0d want 5", n_en); end
        for (int i = 0; i < 5; i++) begin
            tests_run++; if (en_at[i] !== 4 * (i + 1)) begin tests_failed++; $display("FAIL up1_en_time[%0d]: got cycle %0d want %0d", i, en_at[i], 4 * (i + 1)); end
        end
        tests_run++; if (done_at !== 24) begin tests_failed++; $display("FAIL up1_done_time: got cycle %0d want 24", done_at); end
        tests_run++; if (o_state !== 2'b11) begin tests_failed++; $display("FAIL up1_state_done: got %b want 11", o_state); end
        tests_run++; if (cnt !== 10'd5) begin tests_failed++; $display("FAIL up1_count: got %0d want 5", cnt); end
    endtask

    task automatic test_down_wrap();
        logic exp_en;
        logic exp_ld;
        i_up = 1'b0; i_wrap = 1'b1; i_limit = 10'd3;
        press_start();
        tests_run++; if (bus.cnt_load !== 1'b1 || bus.load_val !== 10'd3) begin tests_failed++; $display("FAIL dw_load: got load=%b val=%0d want load=1 val=3", bus.cnt_load, bus.load_val); end
        tests_run++; if (bus.cnt_up !== 1'b0) begin tests_failed++; $display("FAIL dw_dir: got %b want 0", bus.cnt_up); end
        tests_run++; if (o_done !== 1'b0) begin tests_failed++; $display("FAIL dw_done_clr: got %b want 0", o_done); end
        for (int c = 1; c <= 48; c++) begin
            step();
            exp_en = (c % 4 == 0) && (c % 16 != 0);
            exp_ld = (c % 16 == 0);
            tests_run++;
            if (bus.cnt_en !== exp_en || bus.cnt_load !== exp_ld) begin
                tests_failed++;
                $display("FAIL dw_strobe@%0d: got en=%b load=%b want en=%b load=%b", c, bus.cnt_en, bus.cnt_load, exp_en, exp_ld);
            end
            if (exp_ld) begin
                tests_run++; if (bus.load_val !== 10'd3) begin tests_failed++; $display("FAIL dw_reload_val@%0d: got %0d want 3", c, bus.load_val); end
            end
        end
        step();
        tests_run++; if (cnt !== 10'd3) begin tests_failed++; $display("FAIL dw_count: got %0d want 3", cnt); end
    endtask

    task automatic test_pause();
        int strobes = 0;
        int bad_st  = 0;
        i_up = 1'b1; i_wrap = 1'b1; i_limit = 10'd20;
        press_start();
        repeat (3) step();
        // Key goes low now so the pause lands two cycles after the next tick.
        i_pause_n = 1'b0;
        step();
        tests_run++; if (bus.cnt_en !== 1'b1) begin tests_failed++; $display("FAIL pause_tick: got en=%b want 1", bus.cnt_en); end
        i_pause_n = 1'b1;
        step();
        step();
        tests_run++; if (o_state !== 2'b10) begin tests_failed++; $display("FAIL pause_state: got %b want 10", o_state); end
        for (int c = 0; c < 100; c++) begin
            step();
            if (bus.cnt_en !== 1'b0 || bus.cnt_load !== 1'b0) strobes++;
            if (o_state !== 2'b10) bad_st++;
        end
        tests_run++; if (strobes !== 0) begin tests_failed++; $display("FAIL pause_quiet: got %0d strobe cycles want 0", strobes); end
        tests_run++; if (bad_st !== 0) begin tests_failed++; $display("FAIL pause_hold: got %0d non-PAUSE cycles want 0", bad_st); end
        i_pause_n = 1'b0;
        repeat (3) step();
        i_pause_n = 1'b1;
        tests_run++; if (o_state !== 2'b01) begin tests_failed++; $display("FAIL resume_state: got %b want 01", o_state); end
        step();
        tests_run++; if (bus.cnt_en !== 1'b0) begin tests_failed++; $display("FAIL resume_early: got en=%b want 0", bus.cnt_en); end
        step();
        tests_run++; if (bus.cnt_en !== 1'b1) begin tests_failed++; $display("FAIL resume_tick: got en=%b want 1", bus.cnt_en); end
        step();
        tests_run++; if (cnt !== 10'd2) begin tests_failed++; $display("FAIL resume_count: got %0d want 2", cnt); end
    endtask

    task automatic test_simultaneous();
        int waited = 0;
        while (cnt !== 10'd7 && waited < 60) begin
            step();
            waited++;
        end
        tests_run++; if (cnt !== 10'd7) begin tests_failed++; $display("FAIL sim_reach7: got %0d want 7", cnt); end
        i_up = 1'b1;
        i_start_n = 1'b0;
        i_pause_n = 1'b0;
        repeat (3) step();
        i_start_n = 1'b1;
        i_pause_n = 1'b1;
        tests_run++; if (bus.cnt_load !== 1'b1 || bus.load_val !== 10'd0) begin tests_failed++; $display("FAIL sim_load: got load=%b val=%0d want load=1 val=0", bus.cnt_load, bus.load_val); end
        tests_run++; if (bus.cnt_en !== 1'b0) begin tests_failed++; $display("FAIL sim_no_en: got %b want 0", bus.cnt_en); end
        tests_run++; if (o_state !== 2'b01) begin tests_failed++; $display("FAIL sim_state: got %b want 01", o_state); end
        for (int c = 1; c <= 4; c++) begin
            step();
            tests_run++;
            if (bus.cnt_en !== (c == 4) || o_state !== 2'b01) begin
                tests_failed++;
                $display("FAIL sim_presc@%0d: got en=%b state=%b want en=%b state=01", c, bus.cnt_en, o_state, (c == 4));
            end
        end
        tests_run++; if (cnt !== 10'd0) begin tests_failed++; $display("FAIL sim_count: got %0d want 0", cnt); end
    endtask

    task automatic test_reset_mid_run();
        int strobes = 0;
        int bad_st  = 0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        tests_run++; if (o_state !== 2'b00) begin tests_failed++; $display("FAIL rst_run_state: got %b want 00", o_state); end
        tests_run++; if (bus.cnt_up !== 1'b0 || bus.load_val !== 10'd0) begin tests_failed++; $display("FAIL rst_run_regs: got up=%b val=%0d want up=0 val=0", bus.cnt_up, bus.load_val); end
        for (int c = 0; c < 30; c++) begin
            if (bus.cnt_en !== 1'b0 || bus.cnt_load !== 1'b0) strobes++;
            if (o_state !== 2'b00) bad_st++;
            step();
        end
        tests_run++; if (strobes !== 0) begin tests_failed++; $display("FAIL rst_run_quiet: got %0d strobe cycles want 0", strobes); end
        tests_run++; if (bad_st !== 0) begin tests_failed++; $display("FAIL rst_run_idle: got %0d non-IDLE cycles want 0", bad_st); end
    endtask

    task automatic test_start_in_done();
        int n_en = 0;
        // Up one-shot with limit 0 ends at the very first tick.
        i_up = 1'b1; i_wrap = 1'b0; i_limit = 10'd0;
        press_start();
        tests_run++; if (bus.cnt_load !== 1'b1 || bus.load_val !== 10'd0) begin tests_failed++; $display("FAIL lim0_load: got load=%b val=%0d want load=1 val=0", bus.cnt_load, bus.load_val); end
        for (int c = 1; c <= 14; c++) begin
            step();
            if (bus.cnt_en === 1'b1) n_en++;
            if (c == 4) begin
                tests_run++; if (o_state !== 2'b11 || o_done !== 1'b1) begin tests_failed++; $display("FAIL lim0_done: got state=%b done=%b want 11/1", o_state, o_done); end
            end
        end
        tests_run++; if (n_en !== 0) begin tests_failed++; $display("FAIL lim0_no_en: got %0d enables want 0", n_en); end
        // Start from DONE: down one-shot 2 -> 0.
        i_up = 1'b0; i_limit = 10'd2;
        press_start();
        tests_run++; if (bus.cnt_load !== 1'b1 || bus.load_val !== 10'd2) begin tests_failed++; $display("FAIL done_restart_load: got load=%b val=%0d want load=1 val=2", bus.cnt_load, bus.load_val); end
        tests_run++; if (o_state !== 2'b01 || o_done !== 1'b0) begin tests_failed++; $display("FAIL done_restart_state: got state=%b done=%b want 01/0", o_state, o_done); end
        n_en = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.cnt_en === 1'b1) n_en++;
        end
        tests_run++; if (n_en !== 2) begin tests_failed++; $display("FAIL down1_en_count: got %0d want 2", n_en); end
        tests_run++; if (o_state !== 2'b11 || cnt !== 10'd0) begin tests_failed++; $display("FAIL down1_end: got state=%b cnt=%0d want 11/0", o_state, cnt); end
    endtask

    task automatic test_limit_zero_wrap();
        logic exp_ld;
        i_up = 1'b1; i_wrap = 1'b1; i_limit = 10'd0;
        press_start();
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_ld = (c % 4 == 0);
            tests_run++;
            if (bus.cnt_en !== 1'b0 || bus.cnt_load !== exp_ld || (exp_ld && bus.load_val !== 10'd0)) begin
                tests_failed++;
                $display("FAIL lim0_wrap@%0d: got en=%b load=%b val=%0d want en=0 load=%b val=0", c, bus.cnt_en, bus.cnt_load, bus.load_val, exp_ld);
            end
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_start_n = 1'b1;
        i_pause_n = 1'b1;
        i_up      = 1'b0;
        i_wrap    = 1'b0;
        i_limit   = '0;

        test_reset();
        test_up_oneshot();
        repeat (4) step();
        test_down_wrap();
        test_pause();
        test_simultaneous();
        test_reset_mid_run();
        test_start_in_done();
        repeat (4) step();
        test_limit_zero_wrap();

        tests_run++; if (both_cnt !== 0) begin tests_failed++; $display("FAIL en_load_overlap: got %0d cycles want 0", both_cnt); end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_counter_ctrl

// File: doc/counter_ctrl.md
# counter_ctrl

Run controller for the lab synchronous up/down counter. It turns two active-low push-button levels (KEY style) into start/restart and pause/resume commands, and derives a prescaled count-enable tick from the 50 MHz clock. It issues load strobes with the start value, detects the terminal count, and either wraps (reload) or stops (one-shot). It sits between the board keys/switches and the counter datapath, which it drives through enable, direction and load.

## Interface
- `CNT_W`, 10: counter width; matches the 10-bit LED counter.
- `PRESC`, 50_000_000: clock cycles per count tick. Must be ≥ 2. Benches use 4.
- `i_clk` in 1: system clock, 50 MHz.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_start_n` in 1: start key, active-low level, asynchronous to `i_clk`.
- `i_pause_n` in 1: pause key, active-low level, asynchronous.
- `i_up` in 1: direction, 1 = up. Latched at start.
- `i_wrap` in 1: 1 = free-run wrap, 0 = one-shot. Latched at start.
- `i_limit` in CNT_W: up-mode terminal value and down-mode start value. Latched at start.
- `i_cnt_dat` in CNT_W: current counter value, fed back from the counter.
- `o_cnt_en` out 1: one-cycle count-enable tick.
- `o_cnt_up` out 1: latched direction to the counter.
- `o_cnt_load` out 1: one-cycle load strobe.
- `o_load_val` out CNT_W: value to load; valid while `o_cnt_load` is high.
- `o_state` out 2: encoding IDLE=00, RUN=01, PAUSE=10, DONE=11.
- `o_done` out 1: high while in DONE.

## Operation
- **Key inputs**
  - Each key passes through a 2-FF synchronizer and a previous-value register.
  - The command pulse is prev=1 & sync=0, i.e. a falling edge.
  - The synchronizer and previous registers reset to 1 (key released).
- **Start command.** A start edge in any state:
  - latches `i_up`, `i_wrap`, `i_limit`;
  - sets `o_load_val` = up ? 0 : limit and pulses `o_cnt_load`;
  - clears the prescaler and enters RUN.
- **Terminal value:** the latched limit in up mode, 0 in down mode.
- **RUN**
  - The prescaler counts 0..PRESC-1 and wraps.
  - At PRESC-1 a tick occurs, and `i_cnt_dat` is compared with the terminal value:
    - not terminal: pulse `o_cnt_en`;
    - terminal and wrap=1: pulse `o_cnt_load` with the start value, no `o_cnt_en`;
    - terminal and wrap=0: no strobe, go to DONE.
- **Pause**
  - A pause edge in RUN enters PAUSE; the prescaler is frozen and no strobes are issued.
  - A pause edge in PAUSE returns to RUN; the prescaler resumes from its held value.
  - Pause edges in IDLE or DONE are ignored.
- **DONE:** `o_done`=1. Only a start edge leaves DONE.
- **Simultaneous edges:** start wins over pause. `o_cnt_en` and `o_cnt_load` are never high in the same cycle.
- **Limit 0:**
  - up one-shot goes to DONE at the first tick;
  - up wrap reloads 0 every tick.

## Timing
- **Reset values:**
  - state IDLE, prescaler 0;
  - `o_cnt_en`, `o_cnt_up`, `o_cnt_load`, `o_done` = 0;
  - `o_load_val` = 0, `o_state` = 00.
- **Reset mid-operation:** all of the above apply at the next edge. Latched mode, limit and prescaler are discarded; the counter is not loaded.
- **Key held low across reset release:** counts as one new press, one cycle after release plus sync latency.
- **All outputs are registered.**
- **Command latency:** the key is first sampled low at edge k. The strobe and state change are visible after edge k+2 (3-cycle latency).
- **First tick:** `o_cnt_en` rises PRESC cycles after the `o_cnt_load` cycle. Subsequent ticks follow every PRESC cycles.
- **Counter timing requirement:** the counter applies load or enable on the cycle after the strobe. PRESC ≥ 2 guarantees `i_cnt_dat` is settled at the compare.
- **Pause/resume:** the total RUN cycles between ticks is exactly PRESC, regardless of time spent in PAUSE.

## Structure
- Shared include file `counter_ctrl_defs.vh` holds:
  - state encodings IDLE/RUN/PAUSE/DONE;
  - default `CNT_W`.
- The prescaler width is `$clog2(PRESC)`, local to the block.
- One sub-module, `key_edge`:
  - 2-FF sync plus falling-edge pulse, reset to released;
  - instantiated twice, for start and pause.
- The FSM, prescaler and terminal compare stay in `counter_ctrl`.

## Test plan
All scenarios use PRESC=4, CNT_W=10, and a behavioural counter model in the bench.

1. **Reset:** `i_rst` high for 3 cycles with keys high → all outputs 0, `o_state`=00, and no strobes for 50 cycles.
2. **Up one-shot** (up=1, wrap=0, limit=5), start press:
   - load val 0 three cycles after the press;
   - 5 `o_cnt_en` pulses, 4 cycles apart;
   - counter reaches 5, then DONE with `o_done`=1 and no sixth enable.
3. **Down wrap** (up=0, wrap=1, limit=3):
   - load 3, then enables through 3→0;
   - at the 0 tick, a load with val 3 and no enable;
   - the pattern repeats 3 times.
4. **Pause:**
   - press pause 2 cycles after a tick → `o_state`=10, no strobes for 100 cycles;
   - resume → next `o_cnt_en` exactly 2 RUN cycles later.
5. **Simultaneous start and pause presses in RUN** with counter=7 → restart load (val 0 for up), state RUN, prescaler cleared.
6. **Reset mid-RUN and start during DONE:**
   - `i_rst` during RUN → IDLE next cycle, no strobes afterwards;
   - separate run: a start press in DONE → reload and RUN.
